// File: rtl/hazard_ctl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, branch flushes, memory-wait freezes.
// Define HAZARD_STATS_EN to build the saturating stall/flush/wait statistics counters.
module hazard_ctl #(
  parameter int LOAD_STALL = 1,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic              idex_memread,
  input  logic [4:0]        idex_rt,
  input  logic              exmem_pcsrc,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events,
  output logic [STAT_W-1:0] wait_cycles
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_STALL   = 2'b01,
    S_MEMWAIT = 2'b10
  } state_t;

  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);
  localparam bit         MULTI_STALL = (LOAD_STALL > 1);

  state_t     r_state, r_ret;
  logic [3:0] r_cnt;

  state_t     w_state_nxt, w_ret_nxt, w_eff;
  logic [3:0] w_cnt_nxt;
  logic       w_lu;
  logic       w_pc_write, w_ifid_write, w_idex_write, w_exmem_write;
  logic       w_idex_bubble, w_ifid_flush, w_idex_flush, w_exmem_flush;

  assign w_lu = idex_memread & (idex_rt != 5'd0) &
                ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Once memory releases, behave as the state we left, within this same cycle.
  assign w_eff = ((r_state == S_MEMWAIT) && !mem_busy) ? r_ret : r_state;

  // State, return-state and stall-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_ret   <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and Mealy control decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret;
    w_cnt_nxt     = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_write  = 1'b1;
    w_exmem_write = 1'b1;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    case (w_eff)
      S_RUN: begin
        if (mem_busy) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_write  = 1'b0;
          w_exmem_write = 1'b0;
          w_state_nxt   = S_MEMWAIT;
          w_ret_nxt     = S_RUN;
        end else if (exmem_pcsrc) begin
          w_ifid_flush  = 1'b1;
          w_idex_flush  = 1'b1;
          w_exmem_flush = 1'b1;
          w_state_nxt   = S_RUN;
        end else if (w_lu) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          if (MULTI_STALL) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = STALL_INIT;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_STALL: begin
        if (mem_busy) begin
          // Freeze with the remaining count held for after the wait.
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_write  = 1'b0;
          w_exmem_write = 1'b0;
          w_state_nxt   = S_MEMWAIT;
          w_ret_nxt     = S_STALL;
        end else if (exmem_pcsrc) begin
          w_ifid_flush  = 1'b1;
          w_idex_flush  = 1'b1;
          w_exmem_flush = 1'b1;
          w_state_nxt   = S_RUN;
          w_cnt_nxt     = 4'd0;
        end else begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          w_cnt_nxt     = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_STALL;
          end
        end
      end
      S_MEMWAIT: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_write  = 1'b0;
        w_exmem_write = 1'b0;
        w_state_nxt   = S_MEMWAIT;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_ret_nxt   = S_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign pc_write    = w_pc_write;
  assign ifid_write  = w_ifid_write;
  assign idex_write  = w_idex_write;
  assign exmem_write = w_exmem_write;
  assign idex_bubble = w_idex_bubble;
  assign ifid_flush  = w_ifid_flush;
  assign idex_flush  = w_idex_flush;
  assign exmem_flush = w_exmem_flush;
  assign state       = r_state;

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic [STAT_W-1:0] r_stall_cycles, r_flush_events, r_wait_cycles;

  // Saturating hazard statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= {STAT_W{1'b0}};
      r_flush_events <= {STAT_W{1'b0}};
      r_wait_cycles  <= {STAT_W{1'b0}};
    end else begin
      if (w_idex_bubble && (r_stall_cycles != STAT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + STAT_ONE;
      end
      if (w_ifid_flush && (r_flush_events != STAT_MAX)) begin
        r_flush_events <= r_flush_events + STAT_ONE;
      end
      if ((r_state == S_MEMWAIT) && (r_wait_cycles != STAT_MAX)) begin
        r_wait_cycles <= r_wait_cycles + STAT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
  assign wait_cycles  = r_wait_cycles;
`else
  assign stall_cycles = {STAT_W{1'b0}};
  assign flush_events = {STAT_W{1'b0}};
  assign wait_cycles  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: one instance with LOAD_STALL=1 (a) and one with LOAD_STALL=3 (b).
module tb_hazard_ctl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       memread;
    logic [4:0] xrt;
    logic       pcsrc;
    logic       busy;
  } in_t;

  typedef struct packed {
    logic        sel;
    logic [9:0]  exp;
    logic        chk;
    logic [15:0] st;
    logic [15:0] fl;
    logic [15:0] wt;
  } exp_t;

  // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] C_DEF = 8'b1111_0000;
  localparam logic [7:0] C_LU  = 8'b0011_1000;
  localparam logic [7:0] C_FL  = 8'b1111_0111;
  localparam logic [7:0] C_FZ  = 8'b0000_0000;
  localparam logic [1:0] RUN = 2'b00, STL = 2'b01, MW = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t in_a, in_b;
  logic [9:0]  out_a, out_b;
  logic [15:0] st_a, fl_a, wt_a, st_b, fl_b, wt_b;
  logic pa, ia, xa, ma, ba, f1a, f2a, f3a, pb, ib, xb, mb, bb, f1b, f2b, f3b;
  logic [1:0] sa, sb;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctl #(.LOAD_STALL(1), .STAT_W(16)) u_dut_a (
    .clk(clk), .rst(in_a.rst), .ifid_rs(in_a.rs), .ifid_rt(in_a.rt),
    .idex_memread(in_a.memread), .idex_rt(in_a.xrt), .exmem_pcsrc(in_a.pcsrc),
    .mem_busy(in_a.busy), .pc_write(pa), .ifid_write(ia), .idex_write(xa),
    .exmem_write(ma), .idex_bubble(ba), .ifid_flush(f1a), .idex_flush(f2a),
    .exmem_flush(f3a), .state(sa), .stall_cycles(st_a), .flush_events(fl_a),
    .wait_cycles(wt_a)
  );

  hazard_ctl #(.LOAD_STALL(3), .STAT_W(16)) u_dut_b (
    .clk(clk), .rst(in_b.rst), .ifid_rs(in_b.rs), .ifid_rt(in_b.rt),
    .idex_memread(in_b.memread), .idex_rt(in_b.xrt), .exmem_pcsrc(in_b.pcsrc),
    .mem_busy(in_b.busy), .pc_write(pb), .ifid_write(ib), .idex_write(xb),
    .exmem_write(mb), .idex_bubble(bb), .ifid_flush(f1b), .idex_flush(f2b),
    .exmem_flush(f3b), .state(sb), .stall_cycles(st_b), .flush_events(fl_b),
    .wait_cycles(wt_b)
  );

  assign out_a = {pa, ia, xa, ma, ba, f1a, f2a, f3a, sa};
  assign out_b = {pb, ib, xb, mb, bb, f1b, f2b, f3b, sb};

  function automatic in_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                             input logic mr, input logic [4:0] xrt, input logic pc,
                             input logic busy);
    in_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.memread = mr; v.xrt = xrt; v.pcsrc = pc; v.busy = busy;
    return v;
  endfunction

  function automatic logic [15:0] sx(input int v);
    return 16'(v) & {16{STATS_ON}};
  endfunction

  task automatic step(input logic sel, input in_t v, input logic [9:0] e, input logic chk,
                      input int st, input int fl, input int wt);
    exp_t x;
    @(posedge clk);
    #1;
    if (sel) in_b = v; else in_a = v;
    x.sel = sel; x.exp = e; x.chk = chk; x.st = sx(st); x.fl = sx(fl); x.wt = sx(wt);
    q.push_back(x);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    logic [9:0] got;
    logic [15:0] gs, gf, gw;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = e.sel ? out_b : out_a;
        gs = e.sel ? st_b : st_a;
        gf = e.sel ? fl_b : fl_a;
        gw = e.sel ? wt_b : wt_a;
        n_tests++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL ctl dut_%s t=%0t got %b need %b", e.sel ? "b" : "a", $time, got, e.exp);
        end
        if (e.chk) begin
          n_tests++;
          if (gs !== e.st) begin
            n_fail++;
            $display("FAIL stall_cycles dut_%s got %0d need %0d", e.sel ? "b" : "a", gs, e.st);
          end
          n_tests++;
          if (gf !== e.fl) begin
            n_fail++;
            $display("FAIL flush_events dut_%s got %0d need %0d", e.sel ? "b" : "a", gf, e.fl);
          end
          n_tests++;
          if (gw !== e.wt) begin
            n_fail++;
            $display("FAIL wait_cycles dut_%s got %0d need %0d", e.sel ? "b" : "a", gw, e.wt);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_a = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    in_b = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    in_b = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // LOAD_STALL=1
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd2, 5'd5, 1'b1, 5'd2, 1'b0, 1'b0), {C_LU,  RUN}, 1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd2, 5'd5, 1'b0, 5'd2, 1'b0, 1'b0), {C_DEF, RUN}, 1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0), {C_FL,  RUN}, 1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 1, 1, 0);
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1), {C_FZ,  RUN}, 1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1), {C_FZ,  MW},  1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0), {C_FL,  MW},  1'b0, 0, 0, 0);
    step(1'b0, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 1, 2, 2);

    // LOAD_STALL=3: plain three-bubble stall
    step(1'b1, mk(1'b0, 5'd1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0), {C_LU,  RUN}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_LU,  STL}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_LU,  STL}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 3, 0, 0);
    step(1'b1, mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b0, 0, 0, 0);

    // Memory wait of four busy cycles in the middle of a stall
    step(1'b1, mk(1'b0, 5'd1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0), {C_LU,  RUN}, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), {C_FZ, (i == 0) ? STL : MW},
           1'b0, 0, 0, 0);
    end
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_LU,  MW},  1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_LU,  STL}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 3, 0, 4);

    // Branch aborts a stall; branch beats load-use in RUN
    step(1'b1, mk(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0), {C_LU,  RUN}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0), {C_FL,  STL}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0), {C_FL,  RUN}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 4, 2, 4);

    // Reset while stalled
    step(1'b1, mk(1'b0, 5'd6, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0), {C_LU,  RUN}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_LU,  STL}, 1'b0, 0, 0, 0);
    step(1'b1, mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), {C_DEF, RUN}, 1'b1, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath.
- Watches the IF/ID instruction fields, ID/EX load status, the EX/MEM branch decision and the data-memory busy flag.
- Drives PC and latch write-enables, bubble insertion into ID/EX, and stage flushes.
- Sits beside the decode stage and sequences fetch and decode around load-use, branch and memory-wait hazards.

Parameters:
LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..15)
STAT_W, 16, width of optional statistics counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
ifid_rs  input  5  IF/ID instr[25:21]
ifid_rt  input  5  IF/ID instr[20:16]
idex_memread  input  1  ID/EX M-control memread bit
idex_rt  input  5  ID/EX instrout_2016
exmem_pcsrc  input  1  branch taken, resolved in MEM
mem_busy  input  1  data memory not ready; freeze pipeline
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
idex_write  output  1  ID/EX load enable
exmem_write  output  1  EX/MEM and MEM/WB load enable
idex_bubble  output  1  force ID/EX control fields (WB, M, EX) to zero
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  clear ID/EX to NOP
exmem_flush  output  1  clear EX/MEM control
state  output  2  00 RUN, 01 STALL, 10 MEMWAIT
stall_cycles  output  STAT_W  stall statistic
flush_events  output  STAT_W  flush statistic
wait_cycles  output  STAT_W  memory-wait statistic

Behaviour:
- Single clock `clk`; synchronous active-high `rst`. The whole block runs on one clock domain.
- Reset state: RUN, cnt=0, ret=RUN, counters=0.
- Outputs are Mealy: decoded combinationally from the current state and inputs, and acting in the same cycle.
- Defaults: every write enable =1, every flush and idex_bubble =0.
- Load-use hazard (lu): idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- Event priority: mem_busy > exmem_pcsrc > lu.
- RUN:
  - mem_busy: pc_write=ifid_write=idex_write=exmem_write=0; no flush. Next state MEMWAIT, ret=RUN.
  - else pcsrc: ifid_flush=idex_flush=exmem_flush=1, pc_write=1. Stay in RUN.
  - else lu: pc_write=ifid_write=0, idex_bubble=1. If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1; else stay in RUN.
- STALL:
  - Outputs as for lu (hold PC and IF/ID, bubble ID/EX).
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - pcsrc: flush outputs as in RUN, pc_write=1, abort the stall, next state RUN, cnt=0.
  - mem_busy: freeze outputs, next state MEMWAIT, ret=STALL, cnt held.
- MEMWAIT:
  - All write enables =0; flushes and bubble =0; pcsrc ignored.
  - When mem_busy=0, the freeze lifts and the return state is evaluated in that same cycle (pcsrc, lu and cnt take effect then).
- Reset mid-stall or mid-wait: next edge forces RUN; outputs take RUN defaults from the cycle after reset deasserts.
- Rules:
  - pc_write and ifid_write are never 0 while pcsrc is acted on.
  - idex_bubble and idex_flush are never both 1.

Optional Feature:
- HAZARD_STATS_EN defined:
  - stall_cycles increments each cycle idex_bubble=1.
  - flush_events increments each cycle ifid_flush=1.
  - wait_cycles increments each MEMWAIT cycle.
  - All three saturate at all-ones and clear on rst.
- Undefined: all three outputs are tied to 0 and no counter flops exist.

Test Plan:
- lw $2 in ID/EX (memread=1, idex_rt=2), IF/ID rs=2 -> 1 cycle: pc_write=0, ifid_write=0, idex_bubble=1; next cycle memread=0 -> all defaults.
- idex_rt=0 with memread=1 and ifid_rs=0 -> no stall, all enables=1.
- LOAD_STALL=3, lu pulse -> 3 consecutive bubble cycles, state 00→01→01→00.
- exmem_pcsrc=1 while lu=1 -> three flushes=1, pc_write=1, idex_bubble=0.
- LOAD_STALL=3, mem_busy=1 for 4 cycles mid-STALL -> all enables 0 for 4 cycles, then the remaining stall cycles complete; with HAZARD_STATS_EN, wait_cycles=4 and stall_cycles=3.
- rst asserted in STALL -> next cycle state=00, counters=0, enables=1.
